if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register. Sits directly upstream of the ID-stage decoder/control unit and consumes that unit's PCSrc output.
- Holds the PC and issues requests to the instruction memory over a req/ack handshake. Presents the fetched instruction and PC+4 to ID.
- Computes the next PC from PCSrc: sequential, branch, J or JR.
- Handles ID stalls with a one-entry skid buffer and squashes wrong-path fetches on redirect. The ISA has no branch delay slot.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_src  in  2  redirect select from ID control: 0 = +4, 1 = branch, 2 = J, 3 = JR.
- br_imm  in  16  instr[15:0] of the ID instruction.
- j_index  in  26  instr[25:0] of the ID instruction.
- jr_target  in  32  Reg[rs] read in ID.
- id_stall  in  1  ID cannot accept a new instruction this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_rdata  in  32  instruction, valid only when imem_ack = 1.
- imem_ack  in  1  single-cycle completion pulse; may arrive in the same cycle as imem_req rises.
- ifid_valid  out  1  IF/ID holds a live instruction.
- ifid_instr  out  32  instruction to ID.
- ifid_pc4  out  32  PC+4 of ifid_instr.

Behaviour:
- Reset (rst = 1 at an edge): pc = RESET_PC, pend_pc = 0, skid = 0, ifid_valid = 0, ifid_instr = 0, ifid_pc4 = 0, state = S_BOOT. imem_req = 0 in S_BOOT.
- Reset mid-transaction: all state is discarded. imem is reset by the same rst, and an ack seen in S_BOOT is ignored.
- Combinational outputs: imem_addr = pc at all times. imem_req = 1 in S_FETCH and S_DROP, 0 otherwise.
- consume = ifid_valid & ~id_stall.
- redirect = consume & (pc_src != 0). pc_src is ignored when ifid_valid = 0 or id_stall = 1.
- Redirect target, all arithmetic mod 2^32:
  - branch: ifid_pc4 + {{14{br_imm[15]}}, br_imm, 2'b00}.
  - J: {ifid_pc4[31:28], j_index, 2'b00}.
  - JR: jr_target; bits [1:0] are forced to 0.
- imem rule: once imem_req = 1, imem_addr stays stable until imem_ack. Requests are never cancelled.
- FSM states: S_BOOT, S_FETCH, S_DROP, S_HOLD.
- S_BOOT -> S_FETCH unconditionally, one cycle.
- S_FETCH, first matching case applies:
  - redirect & imem_ack: rdata discarded; pc <= target; ifid_valid <= 0; stay in S_FETCH.
  - redirect & ~imem_ack: pend_pc <= target; ifid_valid <= 0; -> S_DROP.
  - imem_ack & (~ifid_valid | ~id_stall): ifid <= {imem_rdata, pc+4}; ifid_valid <= 1; pc <= pc+4.
  - imem_ack & ifid_valid & id_stall: skid <= {imem_rdata, pc+4}; pc <= pc+4; -> S_HOLD.
  - no ack & consume: ifid_valid <= 0.
- S_DROP:
  - Waits for imem_ack, then discards rdata; pc <= pend_pc; -> S_FETCH.
  - ifid_valid stays 0 throughout.
- S_HOLD (imem_req = 0, ifid_valid = 1):
  - id_stall: hold.
  - redirect: skid dropped; pc <= target; ifid_valid <= 0; -> S_FETCH.
  - consume with no redirect: ifid <= skid; ifid_valid stays 1; -> S_FETCH.
- Timing:
  - Latency: address to ifid_valid is one cycle after imem_ack.
  - Zero-wait memory sustains one instruction per cycle.
  - Taken redirect costs one bubble with zero-wait memory.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.

Test Plan:
- rst, then zero-wait imem returning instr = addr: ifid_pc4 sequence 4, 8, 12, ...; ifid_valid = 1 from the 3rd cycle after rst deasserts; imem_req = 0 in the S_BOOT cycle.
- BEQ taken: ifid_pc4 = 0x14, pc_src = 1, br_imm = 0xFFFE. Next imem_addr = 0x0C; the in-flight fetch of 0x14 is squashed with ifid_valid = 0 for one cycle; next ifid_pc4 = 0x10.
- J with imem latency 3: redirect 2 cycles into a request, ifid_pc4 = 0x3000_0008, j_index = 0x40. The old address is held until ack and its data discarded; then imem_addr = 0x3000_0100.
- JR while id_stall = 1 for 2 cycles with jr_target = 0x0000_2003: no redirect while stalled; the ack that arrives during the stall goes to skid. Once the stall drops: skid dropped, imem_addr = 0x0000_2000.
- id_stall held 4 cycles with a sequential stream: exactly one extra instruction is buffered and imem_req = 0. After release the instructions come out in order with no loss or duplication.
- RESET_PC = 32'hFFFF_FFFC: the second fetch address is 0x0000_0000. rst asserted while in S_DROP: next state S_BOOT, ifid_valid = 0, and the subsequent fetch address is RESET_PC.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage plus IF/ID pipeline register.
//
// Holds the PC and fetches from instruction memory over a req/ack handshake.
// The fetched instruction and its PC+4 go to ID. PCSrc from ID selects a
// redirect (branch, J, JR). ID stalls are absorbed by a one-entry skid
// buffer. A fetch that is in flight when a redirect happens is completed and
// its data thrown away.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pc_src       redirect select from ID: 0 seq, 1 branch, 2 J, 3 JR
//   br_imm       instr[15:0] of the ID instruction
//   j_index      instr[25:0] of the ID instruction
//   jr_target    Reg[rs] read in ID
//   id_stall     ID cannot accept a new instruction this cycle
//   imem_req     fetch request (held until imem_ack)
//   imem_addr    word-aligned fetch address (always equals the PC)
//   imem_rdata   fetched instruction, valid with imem_ack
//   imem_ack     single-cycle completion pulse, may arrive with imem_req
//   ifid_valid   IF/ID holds a live instruction
//   ifid_instr   instruction to ID
//   ifid_pc4     PC+4 of ifid_instr
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_src,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DROP, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic        consume;
  logic        redirect;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] target;

  // Redirect target, computed from the instruction currently sitting in ID.
  always_comb begin
    br_offset = {{14{br_imm[15]}}, br_imm, 2'b00};
    case (pc_src)
      2'd1:    target = ifid_pc4_q + br_offset;
      2'd2:    target = {ifid_pc4_q[31:28], j_index, 2'b00};
      2'd3:    target = jr_target & 32'hFFFF_FFFC;
      default: target = pc_plus4;
    endcase
  end

  assign pc_plus4   = pc_q + 32'd4;
  assign consume    = ifid_valid_q & ~id_stall;
  assign redirect   = consume & (pc_src != 2'd0);
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == S_FETCH) || (state_q == S_DROP);
  assign ifid_valid = ifid_valid_q;
  assign ifid_instr = ifid_instr_q;
  assign ifid_pc4   = ifid_pc4_q;

  // Next-state logic. A request, once raised, is never withdrawn, so a
  // redirect without an ack parks the target in pend_pc until the stale
  // fetch completes (S_DROP).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end

      S_FETCH: begin
        if (redirect && imem_ack) begin
          pc_d         = target;
          ifid_valid_d = 1'b0;
        end else if (redirect) begin
          pend_pc_d    = target;
          ifid_valid_d = 1'b0;
          state_d      = S_DROP;
        end else if (imem_ack && (!ifid_valid_q || !id_stall)) begin
          ifid_instr_d = imem_rdata;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
        end else if (imem_ack) begin
          skid_instr_d = imem_rdata;
          skid_pc4_d   = pc_plus4;
          pc_d         = pc_plus4;
          state_d      = S_HOLD;
        end else if (consume) begin
          ifid_valid_d = 1'b0;
        end
      end

      S_DROP: begin
        if (imem_ack) begin
          pc_d    = pend_pc_q;
          state_d = S_FETCH;
        end
      end

      S_HOLD: begin
        // ifid_valid is always 1 here, so consume reduces to ~id_stall.
        if (redirect) begin
          pc_d         = target;
          ifid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (consume) begin
          ifid_instr_d = skid_instr_q;
          ifid_pc4_d   = skid_pc4_q;
          state_d      = S_FETCH;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'd0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

endmodule
